block_mem_responder: RTL and testbench

- Memory-side responder for the cache's block-transfer interface: accepts 4-word block read (fetch) and block write (write-back) requests and answers after a fixed, parameterised latency.
- Holds the backing store as a word array organised in 4-word blocks.
- Sits between the cache and the testbench/top level; replaces the ad-hoc memory model.

---
 rtl/block_mem_responder.sv | 153 +++++++++++++++
 tb/tb_block_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_mem_responder.sv
// block_mem_responder: block-transfer memory responder for the cache.
// Serves 4-word block reads and writes after fixed read/write latencies.
// Ports: clk, reset_n; mem_read_req/mem_write_req, mem_addr, wr_data_1..4 in;
// rd_data_1..4, mem_ready, busy, num_reads, num_writes out.
module block_mem_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_BLOCKS    = 64,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read_req,
  input  logic                 mem_write_req,
  input  logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] wr_data_1,
  input  logic [WORD_SIZE-1:0] wr_data_2,
  input  logic [WORD_SIZE-1:0] wr_data_3,
  input  logic [WORD_SIZE-1:0] wr_data_4,
  output logic [WORD_SIZE-1:0] rd_data_1,
  output logic [WORD_SIZE-1:0] rd_data_2,
  output logic [WORD_SIZE-1:0] rd_data_3,
  output logic [WORD_SIZE-1:0] rd_data_4,
  output logic                 mem_ready,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes
);

  localparam int BW = $clog2(MEM_BLOCKS);
  localparam logic [3:0] RD_LD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LD = 4'(WRITE_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    DONE
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 armed;
  logic                 op_wr;
  logic [BW-1:0]        blk;
  logic [WORD_SIZE-1:0] wbuf [4];
  logic [WORD_SIZE-1:0] store [MEM_BLOCKS*4];

  logic [BW-1:0] req_blk;
  logic          any_req;
  logic          commit;
  logic          unused_addr;

  // Block index wraps: only the low BW bits above the word offset matter.
  assign req_blk     = mem_addr[BW+1:2];
  assign any_req     = mem_read_req | mem_write_req;
  assign commit      = (state == WRITE_WAIT) && (cnt == '0);
  assign unused_addr = ^{mem_addr[WORD_SIZE-1:BW+2], mem_addr[1:0]};

  // Backing store survives reset; commit is qualified by FSM state,
  // which reset forces to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (commit) begin
      store[{blk, 2'd0}] <= wbuf[0];
      store[{blk, 2'd1}] <= wbuf[1];
      store[{blk, 2'd2}] <= wbuf[2];
      store[{blk, 2'd3}] <= wbuf[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      armed      <= 1'b1;
      op_wr      <= 1'b0;
      blk        <= '0;
      wbuf[0]    <= '0;
      wbuf[1]    <= '0;
      wbuf[2]    <= '0;
      wbuf[3]    <= '0;
      rd_data_1  <= '0;
      rd_data_2  <= '0;
      rd_data_3  <= '0;
      rd_data_4  <= '0;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      num_reads  <= '0;
      num_writes <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (armed && any_req) begin
            blk  <= req_blk;
            busy <= 1'b1;
            // Write-back wins over a simultaneous fetch.
            if (mem_write_req) begin
              op_wr   <= 1'b1;
              wbuf[0] <= wr_data_1;
              wbuf[1] <= wr_data_2;
              wbuf[2] <= wr_data_3;
              wbuf[3] <= wr_data_4;
              cnt     <= WR_LD;
              state   <= WRITE_WAIT;
            end else begin
              op_wr <= 1'b0;
              cnt   <= RD_LD;
              state <= READ_WAIT;
            end
          end else if (!any_req) begin
            armed <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (cnt == '0) begin
            rd_data_1 <= store[{blk, 2'd0}];
            rd_data_2 <= store[{blk, 2'd1}];
            rd_data_3 <= store[{blk, 2'd2}];
            rd_data_4 <= store[{blk, 2'd3}];
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          busy      <= 1'b0;
          // A request still held must drop before the next accept.
          armed     <= 1'b0;
          if (op_wr) begin
            if (num_writes != '1) num_writes <= num_writes + ONE;
          end else begin
            if (num_reads != '1) num_reads <= num_reads + ONE;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: directed + random checks of block_mem_responder
// against an array-based memory model; second instance for short latency.
module tb_block_mem_responder;

  localparam int RL = 4;
  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rreq, wreq;
  logic [15:0] addr;
  logic [15:0] wd [4];
  logic [15:0] rd [4];
  logic        mem_ready, busy;
  logic [15:0] num_reads, num_writes;

  logic       r1, w1;
  logic [7:0] a1;
  logic [7:0] wd1 [4];
  logic [7:0] rd1 [4];
  logic       rdy1, busy1;
  logic [7:0] nr1, nw1;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mdl [64][4];
  logic [15:0] exp_rd [4];
  int          exp_nr, exp_nw;
  int          wq [$];

  always #5 clk = ~clk;

  block_mem_responder u_dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read_req(rreq), .mem_write_req(wreq), .mem_addr(addr),
    .wr_data_1(wd[0]), .wr_data_2(wd[1]),
    .wr_data_3(wd[2]), .wr_data_4(wd[3]),
    .rd_data_1(rd[0]), .rd_data_2(rd[1]),
    .rd_data_3(rd[2]), .rd_data_4(rd[3]),
    .mem_ready(mem_ready), .busy(busy),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  block_mem_responder #(
    .WORD_SIZE(8), .MEM_BLOCKS(16),
    .READ_LATENCY(1), .WRITE_LATENCY(2)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .mem_read_req(r1), .mem_write_req(w1), .mem_addr(a1),
    .wr_data_1(wd1[0]), .wr_data_2(wd1[1]),
    .wr_data_3(wd1[2]), .wr_data_4(wd1[3]),
    .rd_data_1(rd1[0]), .rd_data_2(rd1[1]),
    .rd_data_3(rd1[2]), .rd_data_4(rd1[3]),
    .mem_ready(rdy1), .busy(busy1),
    .num_reads(nr1), .num_writes(nw1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts();
    check("num_reads", num_reads, exp_nr);
    check("num_writes", num_writes, exp_nw);
  endtask

  // One transaction on the main instance; drop_at = cycle after
  // acceptance when requests are released early (0 = hold to end),
  // hold = extra cycles the request stays up after mem_ready.
  task automatic txn(input bit do_rd, input bit do_wr,
                     input logic [15:0] a, input int drop_at,
                     input int hold);
    int b;
    int k;
    logic [15:0] d [4];
    b = int'(a[7:2]);
    for (int j = 0; j < 4; j++) d[j] = wd[j];
    rreq = do_rd;
    wreq = do_wr;
    addr = a;
    @(posedge clk); #1;
    check("busy_accept", busy, 1);
    addr = 16'($urandom);
    for (int j = 0; j < 4; j++) wd[j] = 16'($urandom);
    k = 0;
    while (k < 20 && mem_ready !== 1'b1) begin
      @(posedge clk); #1;
      k++;
      if (k == drop_at) begin
        rreq = 1'b0;
        wreq = 1'b0;
      end
    end
    check("latency", k, do_wr ? WL : RL);
    check("busy_done", busy, 1);
    if (do_wr) begin
      for (int j = 0; j < 4; j++) mdl[b][j] = d[j];
      wq.push_back(b);
      if (exp_nw < 16'hFFFF) exp_nw++;
    end else begin
      for (int j = 0; j < 4; j++) exp_rd[j] = mdl[b][j];
      if (exp_nr < 16'hFFFF) exp_nr++;
    end
    for (int j = 0; j < 4; j++) check("rd_data", rd[j], exp_rd[j]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("no_dup", mem_ready, 0);
    end
    rreq = 1'b0;
    wreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_idle", busy, 0);
    check_counts();
  endtask

  task automatic t1(input bit do_wr, input logic [7:0] a);
    int k;
    r1 = !do_wr;
    w1 = do_wr;
    a1 = a;
    @(posedge clk); #1;
    k = 0;
    while (k < 20 && rdy1 !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    check("lat_short", k, do_wr ? 2 : 1);
    r1 = 1'b0;
    w1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    logic [5:0]  bb;
    int          op;
    reset_n = 1'b0;
    rreq = 1'b0; wreq = 1'b0; addr = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0;
    for (int j = 0; j < 4; j++) begin
      wd[j] = '0; wd1[j] = '0; exp_rd[j] = '0;
    end
    exp_nr = 0;
    exp_nw = 0;
    #12;
    for (int j = 0; j < 4; j++) check("rst_rd", rd[j], 0);
    check("rst_ready", mem_ready, 0);
    check("rst_busy", busy, 0);
    check_counts();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_ready", mem_ready, 0);

    // Preload block 3, then read it through an unaligned address.
    wd[0] = 16'h1111; wd[1] = 16'h2222;
    wd[2] = 16'h3333; wd[3] = 16'h4444;
    txn(0, 1, 16'h000C, 0, 0);
    txn(1, 0, 16'h000D, 0, 0);

    // Write block 4, read back, then through an aliasing address.
    wd[0] = 16'hAAAA; wd[1] = 16'hBBBB;
    wd[2] = 16'hCCCC; wd[3] = 16'hDDDD;
    txn(0, 1, 16'h0010, 0, 0);
    txn(1, 0, 16'h0013, 0, 0);
    txn(1, 0, 16'h0110, 0, 0);

    // Both requests: write wins; request held past completion.
    wd[0] = 16'h5555; wd[1] = 16'h6666;
    wd[2] = 16'h7777; wd[3] = 16'h8888;
    txn(1, 1, 16'h0020, 0, 3);
    txn(1, 0, 16'h0022, 0, 0);

    // Reset during WRITE_WAIT with two cycles left: write discarded.
    wd[0] = 16'h9999; wd[1] = 16'h9999;
    wd[2] = 16'h9999; wd[3] = 16'h9999;
    wreq = 1'b1;
    addr = 16'h0020;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", mem_ready, 0);
    for (int j = 0; j < 4; j++) check("abort_rd", rd[j], 0);
    exp_nr = 0;
    exp_nw = 0;
    for (int j = 0; j < 4; j++) exp_rd[j] = '0;
    check_counts();
    wreq = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_quiet", mem_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 0, 16'h0020, 0, 0);

    // Request dropped right after acceptance still completes.
    txn(1, 0, 16'h000C, 1, 0);

    // Random mix against the model.
    for (int i = 0; i < 40; i++) begin
      op = (wq.size() == 0) ? 0 : int'($urandom_range(0, 2));
      if (op == 1) bb = 6'(wq[$urandom_range(0, wq.size() - 1)]);
      else bb = 6'($urandom);
      a = {8'($urandom), bb, 2'($urandom)};
      for (int j = 0; j < 4; j++) wd[j] = 16'($urandom);
      txn(op != 0, op != 1, a, int'($urandom_range(0, 3)), 0);
    end

    // Short-latency instance: timing, data and count saturation.
    wd1[0] = 8'h5A; wd1[1] = 8'hA5; wd1[2] = 8'h3C; wd1[3] = 8'hC3;
    t1(1, 8'h18);
    for (int i = 0; i < 258; i++) t1(0, 8'h59);
    check("sat_reads", nr1, 8'hFF);
    check("short_writes", nw1, 1);
    check("short_rd0", rd1[0], 8'h5A);
    check("short_rd1", rd1[1], 8'hA5);
    check("short_rd2", rd1[2], 8'h3C);
    check("short_rd3", rd1[3], 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
